// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, debouncer, press/release strobes and auto-repeat; ports clk, reset (sync active-low), in, repeat_en -> level, press, rel, rpt, act
module button_conditioner #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] rpt,
  output logic [N_CH-1:0] act
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic s, flip, lvl, lvl_nxt, fire, press_q, rel_q, rpt_q, act_q;
    rpt_state_t st, st_nxt;
    assign s       = sync[SYNC_STAGES-1];
    assign flip    = (s != lvl) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign lvl_nxt = lvl ^ flip;
    always_ff @(posedge clk) begin
      if (!reset) begin
        sync    <= '0;
        dcnt    <= '0;
        lvl     <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync    <= {sync[SYNC_STAGES-2:0], in[c]};
        dcnt    <= (s == lvl || flip) ? '0 : dcnt + DW'(1);
        lvl     <= lvl_nxt;
        press_q <= flip & ~lvl;
        rel_q   <= flip & lvl;
      end
    end
    // Abort uses the post-edge level so a release can never share a cycle with rpt.
    always_comb begin
      st_nxt   = st;
      rcnt_nxt = '0;
      fire     = 1'b0;
      if (!lvl_nxt || !repeat_en[c])
        st_nxt = IDLE;
      else if (st == IDLE)
        st_nxt = DELAY;
      else if (rcnt == (st == DELAY ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1))) begin
        fire   = 1'b1;
        st_nxt = REPEAT;
      end else
        rcnt_nxt = rcnt + RW'(1);
    end
    always_ff @(posedge clk) begin
      if (!reset) begin
        st    <= IDLE;
        rcnt  <= '0;
        rpt_q <= 1'b0;
        act_q <= 1'b0;
      end else begin
        st    <= st_nxt;
        rcnt  <= rcnt_nxt;
        rpt_q <= fire;
        act_q <= (flip & ~lvl) | fire;
      end
    end
    assign level[c] = lvl;
    assign press[c] = press_q;
    assign rel[c]   = rel_q;
    assign rpt[c]   = rpt_q;
    assign act[c]   = act_q;
  end
endmodule
